// File: rtl/match_pkg.sv
// Shared types and constants for the descriptor match selection stages.
package match_pkg;

  localparam int unsigned DIST_W = 16;
  localparam logic [DIST_W-1:0] DIST_INVALID = 16'hFFFF;

  // Index fields in the result record are sized for the widest supported
  // candidate count; instances narrow them to their own IDX_W at the ports.
  localparam int unsigned MATCH_IDX_W = 16;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  typedef struct packed {
    logic [MATCH_IDX_W-1:0] query_idx;
    logic [MATCH_IDX_W-1:0] train_idx;
    logic [DIST_W-1:0]      best;
    logic [DIST_W-1:0]      second;
    logic                   ok;
  } match_result_t;

endpackage

// File: rtl/match_ratio_test.sv
// Lowe-style ratio test: accept iff best is valid and clearly better than second.
module match_ratio_test
  import match_pkg::*;
#(
  parameter int unsigned RATIO_NUM = 8,
  parameter int unsigned RATIO_DEN = 10
) (
  input  logic [DIST_W-1:0] best,
  input  logic [DIST_W-1:0] second,
  output logic              ok
);

  localparam int unsigned RATIO_MAX = (RATIO_NUM > RATIO_DEN) ? RATIO_NUM : RATIO_DEN;
  localparam int unsigned PROD_W    = DIST_W + $clog2(RATIO_MAX) + 1;
  localparam logic [PROD_W-1:0] NUM_C = PROD_W'(RATIO_NUM);
  localparam logic [PROD_W-1:0] DEN_C = PROD_W'(RATIO_DEN);

  logic [PROD_W-1:0] best_scaled;
  logic [PROD_W-1:0] second_scaled;

  // Cross-multiplied comparison avoids a divider; a missing second always passes.
  always_comb begin
    best_scaled   = PROD_W'(best) * DEN_C;
    second_scaled = PROD_W'(second) * NUM_C;
    ok = (best != DIST_INVALID) &&
         ((second == DIST_INVALID) || (best_scaled < second_scaled));
  end

endmodule

// File: rtl/match_best_select.sv
// Scans a query's candidate distances, keeps best/second-best, and emits one
// ratio-tested match record per query through a single-entry output slot.
module match_best_select
  import match_pkg::*;
#(
  parameter int unsigned MAX_CAND  = 1024,
  parameter int unsigned IDX_W     = $clog2(MAX_CAND),
  parameter int unsigned RATIO_NUM = 8,
  parameter int unsigned RATIO_DEN = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_query_start,
  input  logic [IDX_W-1:0]  i_query_idx,
  input  logic [IDX_W:0]    i_cand_num,
  input  logic              i_dist_ready,
  input  logic [15:0]       i_dist_value,
  output logic              o_busy,
  output logic              o_match_valid,
  input  logic              i_match_ready,
  output logic [IDX_W-1:0]  o_query_idx,
  output logic [IDX_W-1:0]  o_train_idx,
  output logic [15:0]       o_best_dist,
  output logic [15:0]       o_second_dist,
  output logic              o_match_ok,
  output logic              o_overflow
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam match_result_t RESULT_RESET = '{
    query_idx: '0, train_idx: '0, best: DIST_INVALID, second: DIST_INVALID, ok: 1'b0
  };

  state_t            state_q;
  logic [IDX_W-1:0]  query_q;
  logic [CNT_W-1:0]  cand_q;
  logic [CNT_W-1:0]  k_q;
  logic [DIST_W-1:0] best_q;
  logic [DIST_W-1:0] second_q;
  logic [IDX_W-1:0]  best_idx_q;

  logic              scan_start;
  logic              empty_start;
  logic              consume;
  logic              last;
  logic [IDX_W-1:0]  cur_q;
  logic [CNT_W-1:0]  cur_cand;
  logic [CNT_W-1:0]  cur_k;
  logic [DIST_W-1:0] cur_best;
  logic [DIST_W-1:0] cur_second;
  logic [IDX_W-1:0]  cur_idx;
  logic [DIST_W-1:0] upd_best;
  logic [DIST_W-1:0] upd_second;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_ok;
  logic              res_load;
  match_result_t     res_d;
  match_result_t     res_q;
  logic              valid_q;
  logic              overflow_q;

  // A start pulse substitutes fresh scan state for the registers, so a
  // distance arriving with an abort-restart is folded in as index 0 of the new scan.
  always_comb begin
    scan_start  = i_query_start && (i_cand_num != '0);
    empty_start = i_query_start && (i_cand_num == '0);
    if (i_query_start) begin
      cur_q      = i_query_idx;
      cur_cand   = i_cand_num;
      cur_k      = '0;
      cur_best   = DIST_INVALID;
      cur_second = DIST_INVALID;
      cur_idx    = '0;
    end else begin
      cur_q      = query_q;
      cur_cand   = cand_q;
      cur_k      = k_q;
      cur_best   = best_q;
      cur_second = second_q;
      cur_idx    = best_idx_q;
    end
    consume = i_dist_ready && (state_q == S_SCAN) && !empty_start;
    last    = consume && (cur_k == (cur_cand - CNT_ONE));
  end

  // Best/second update for the distance consumed this cycle; ties keep the earlier index.
  always_comb begin
    upd_best   = cur_best;
    upd_second = cur_second;
    upd_idx    = cur_idx;
    if (consume) begin
      if (i_dist_value < cur_best) begin
        upd_second = cur_best;
        upd_best   = i_dist_value;
        upd_idx    = cur_k[IDX_W-1:0];
      end else if (i_dist_value < cur_second) begin
        upd_second = i_dist_value;
      end
    end
  end

  match_ratio_test #(
    .RATIO_NUM (RATIO_NUM),
    .RATIO_DEN (RATIO_DEN)
  ) u_ratio (
    .best   (upd_best),
    .second (upd_second),
    .ok     (upd_ok)
  );

  // Result record for either the final distance of a scan or an empty query.
  always_comb begin
    res_load = last || empty_start;
    if (empty_start) begin
      res_d = RESULT_RESET;
      res_d.query_idx = MATCH_IDX_W'(i_query_idx);
    end else begin
      res_d.query_idx = MATCH_IDX_W'(cur_q);
      res_d.train_idx = MATCH_IDX_W'(upd_idx);
      res_d.best      = upd_best;
      res_d.second    = upd_second;
      res_d.ok        = upd_ok;
    end
  end

  // Scan FSM and running best/second state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      query_q    <= '0;
      cand_q     <= '0;
      k_q        <= '0;
      best_q     <= DIST_INVALID;
      second_q   <= DIST_INVALID;
      best_idx_q <= '0;
    end else begin
      if (empty_start || last) begin
        state_q <= S_IDLE;
      end else if (scan_start) begin
        state_q <= S_SCAN;
      end
      if (scan_start) begin
        query_q <= i_query_idx;
        cand_q  <= i_cand_num;
      end
      if (scan_start || consume) begin
        best_q     <= upd_best;
        second_q   <= upd_second;
        best_idx_q <= upd_idx;
        k_q        <= consume ? (cur_k + CNT_ONE) : cur_k;
      end
    end
  end

  // Single-entry output slot; a result that finds it occupied is dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      res_q      <= RESULT_RESET;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (res_load) begin
      if (valid_q && !i_match_ready) begin
        overflow_q <= 1'b1;
      end else begin
        res_q   <= res_d;
        valid_q <= 1'b1;
      end
    end else if (valid_q && i_match_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_busy        = (state_q == S_SCAN);
  assign o_match_valid = valid_q;
  assign o_query_idx   = IDX_W'(res_q.query_idx);
  assign o_train_idx   = IDX_W'(res_q.train_idx);
  assign o_best_dist   = res_q.best;
  assign o_second_dist = res_q.second;
  assign o_match_ok    = res_q.ok;
  assign o_overflow    = overflow_q;

endmodule
